// File: rtl/gpu_pixel_writeback_if.sv
// Pixel-pair input and VRAM burst output bundle for gpu_pixel_writeback.
// The slave modport is the writeback block; master is the compute stage / memory side.
interface gpu_pixel_writeback_if;
  logic         i_pixValid;
  logic         o_pixReady;
  logic [8:0]   i_pixPairX;
  logic [8:0]   i_pixY;
  logic [31:0]  i_write32;
  logic         i_wrL;
  logic         i_wrR;
  logic         i_flush;
  logic         o_idle;
  logic         o_memValid;
  logic [14:0]  o_memAddr;
  logic [255:0] o_memData;
  logic [15:0]  o_memMask;
  logic         i_memAck;

  modport slave (
    input  i_pixValid, i_pixPairX, i_pixY, i_write32, i_wrL, i_wrR, i_flush, i_memAck,
    output o_pixReady, o_idle, o_memValid, o_memAddr, o_memData, o_memMask
  );

  modport master (
    output i_pixValid, i_pixPairX, i_pixY, i_write32, i_wrL, i_wrR, i_flush, i_memAck,
    input  o_pixReady, o_idle, o_memValid, o_memAddr, o_memData, o_memMask
  );
endinterface

// File: rtl/gpu_pixel_writeback.sv
// Coalesces pixel pairs into 16-pixel masked VRAM bursts (ACC accumulator -> OUT holding register).
// Optional GPU_WB_IDLE_FLUSH_EN: a partial segment self-flushes after IDLE_TIMEOUT idle cycles.
module gpu_pixel_writeback #(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  i_rst,
  gpu_pixel_writeback_if.slave bus
);
  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t       state, stateNext;

  logic [14:0]  accAddr;
  logic [255:0] accData;
  logic [15:0]  accMask;
  logic         accBusy;

  logic [14:0]  outAddr;
  logic [255:0] outData;
  logic [15:0]  outMask;
  logic         outValid;

  logic [14:0]  pairAddr;
  logic         wrAny, outFree, segDiff, ready, fire, wrPair, pushSeg, pushLate, idleHit;
  logic [255:0] mrgData, accNData;
  logic [15:0]  mrgMask, accNMask;
  logic [14:0]  accNAddr;
  logic         accNBusy;

  if (IDLE_TIMEOUT == 0) begin : gBadTimeout
    $error("IDLE_TIMEOUT must be nonzero");
  end

  always_comb begin
    pairAddr = {bus.i_pixY, bus.i_pixPairX[8:3]};
    wrAny    = bus.i_wrL || bus.i_wrR;
    outFree  = !outValid || bus.i_memAck;
    segDiff  = accBusy && (accAddr != pairAddr);
    // Only a pair that would evict ACC into a blocked OUT is back-pressured.
    ready    = !i_rst && (state == ST_RUN) && !(wrAny && segDiff && !outFree);
    fire     = bus.i_pixValid && ready;
    wrPair   = fire && wrAny;
    pushSeg  = wrPair && segDiff;
  end

  // Merged view of ACC after this cycle's pair; a segment change starts from an empty slate.
  always_comb begin
    mrgData = (accBusy && !segDiff) ? accData : '0;
    mrgMask = (accBusy && !segDiff) ? accMask : '0;
    if (bus.i_wrL) begin
      mrgData[{bus.i_pixPairX[2:0], 5'd0} +: 16] = bus.i_write32[15:0];
      mrgMask[{bus.i_pixPairX[2:0], 1'b0}]       = 1'b1;
    end
    if (bus.i_wrR) begin
      mrgData[{bus.i_pixPairX[2:0], 5'd16} +: 16] = bus.i_write32[31:16];
      mrgMask[{bus.i_pixPairX[2:0], 1'b1}]        = 1'b1;
    end
    accNAddr = wrPair ? pairAddr : accAddr;
    accNData = wrPair ? mrgData  : accData;
    accNMask = wrPair ? mrgMask  : accMask;
    accNBusy = accBusy || wrPair;
    pushLate = !pushSeg && accNBusy && outFree &&
               ((accNMask == '1) || (state == ST_DRAIN) || idleHit);
  end

`ifdef GPU_WB_IDLE_FLUSH_EN
  localparam int unsigned CntW = $clog2(IDLE_TIMEOUT + 1);
  logic [CntW-1:0] idleCnt;

  always_ff @(posedge clk) begin
    if (i_rst)                idleCnt <= '0;
    else if (fire)            idleCnt <= CntW'(IDLE_TIMEOUT);
    else if (idleCnt != '0)   idleCnt <= idleCnt - 1'b1;
  end

  assign idleHit = accBusy && !fire && (idleCnt == '0);
`else
  assign idleHit = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN:   if (bus.i_flush && (accNBusy || outValid)) stateNext = ST_DRAIN;
      ST_DRAIN: if (!accBusy && !outValid)                 stateNext = ST_RUN;
      default:  stateNext = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) state <= ST_RUN;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      accAddr <= '0;
      accData <= '0;
      accMask <= '0;
      accBusy <= 1'b0;
    end else if (pushLate) begin
      accMask <= '0;
      accBusy <= 1'b0;
    end else if (wrPair) begin
      accAddr <= pairAddr;
      accData <= mrgData;
      accMask <= mrgMask;
      accBusy <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      outAddr  <= '0;
      outData  <= '0;
      outMask  <= '0;
      outValid <= 1'b0;
    end else if (pushSeg) begin
      outAddr  <= accAddr;
      outData  <= accData;
      outMask  <= accMask;
      outValid <= 1'b1;
    end else if (pushLate) begin
      outAddr  <= accNAddr;
      outData  <= accNData;
      outMask  <= accNMask;
      outValid <= 1'b1;
    end else if (bus.i_memAck) begin
      outValid <= 1'b0;
    end
  end

  assign bus.o_pixReady = ready;
  assign bus.o_idle     = !accBusy && !outValid && (state == ST_RUN);
  assign bus.o_memValid = outValid;
  assign bus.o_memAddr  = outAddr;
  assign bus.o_memData  = outData;
  assign bus.o_memMask  = outMask;
endmodule
